// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] Imem_Addr;
    logic              Imem_Req;
    logic [DATA_W-1:0] Imem_Data;
    logic              Imem_Ready;

    modport master (
        output Imem_Addr,
        output Imem_Req,
        input  Imem_Data,
        input  Imem_Ready
    );

    modport slave (
        input  Imem_Addr,
        input  Imem_Req,
        output Imem_Data,
        output Imem_Ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction register for the multi-cycle core.
// Fetches are stalled until instruction memory answers; a timeout loads a NOOP.
module pc_fetch_unit #(
    parameter int                 DATA_W        = 32,
    parameter logic [DATA_W-1:0]  RESET_PC      = 32'h0000_0000,
    parameter int                 FETCH_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Inst_Reg_Write,
    input  logic              PC_Write_Or,
    input  logic              PC_Write_And,
    input  logic [1:0]        PC_Selector_Source,
    input  logic [1:0]        BorN,
    input  logic              Zero,
    input  logic              Less,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [DATA_W-1:0] ALU_Out,
    pc_fetch_unit_if.master   imem,
    output logic [5:0]        Opcode,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [15:0]       Imm,
    output logic              Stall,
    output logic              Fetch_Error,
    output logic [31:0]       Instr_Count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic              err_q;
    logic [31:0]       count_q;

    logic              stall_s;
    logic              req_s;
    logic              fetch_done_s;
    logic              timeout_s;
    logic              taken_s;
    logic              pc_we_s;

    // Fetch FSM next state, handshake outputs and fetch events
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_s      = 1'b0;
        req_s        = 1'b0;
        fetch_done_s = 1'b0;
        timeout_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_s = Inst_Reg_Write;
                if (Inst_Reg_Write && imem.Imem_Ready) begin
                    fetch_done_s = 1'b1;
                end else if (Inst_Reg_Write) begin
                    stall_s = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                req_s = 1'b1;
                if (imem.Imem_Ready) begin
                    fetch_done_s = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = S_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Last wait cycle: give up, stay stalled so no PC write slips through
                    stall_s   = 1'b1;
                    timeout_s = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Branch resolution and PC next-value selection
    always_comb begin
        taken_s = 1'b0;
        pc_d    = pc_q;
        case (BorN)
            2'b00:   taken_s = Zero;
            2'b01:   taken_s = !Zero;
            2'b10:   taken_s = Less;
            2'b11:   taken_s = Less | Zero;
            default: taken_s = 1'b0;
        endcase
        pc_we_s = PC_Write_Or | (PC_Write_And & taken_s);
        if (pc_we_s && !stall_s) begin
            case (PC_Selector_Source)
                2'b00:   pc_d = ALU_Result;
                2'b01:   pc_d = ALU_Out;
                2'b10:   pc_d = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
                2'b11:   pc_d = pc_q;
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // State, PC, IR, error flag and instruction counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            err_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            if (fetch_done_s) begin
                ir_q    <= imem.Imem_Data;
                count_q <= count_q + 32'd1;
            end else if (timeout_s) begin
                ir_q  <= '0;
                err_q <= 1'b1;
            end else begin
                ir_q <= ir_q;
            end
        end
    end

    assign imem.Imem_Addr = pc_q;
    assign imem.Imem_Req  = req_s;
    assign Stall          = stall_s;
    assign Opcode         = ir_q[31:26];
    assign Rs             = ir_q[25:21];
    assign Rt             = ir_q[20:16];
    assign Rd             = ir_q[15:11];
    assign Imm            = ir_q[15:0];
    assign Fetch_Error    = err_q;
    assign Instr_Count    = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: fetch handshake, branches, jumps, timeout and reset.
module tb_pc_fetch_unit;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Inst_Reg_Write, PC_Write_Or, PC_Write_And;
    logic [1:0]  PC_Selector_Source, BorN;
    logic        Zero, Less;
    logic [31:0] ALU_Result, ALU_Out;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm;
    logic        Stall, Fetch_Error;
    logic [31:0] Instr_Count;

    pc_fetch_unit_if #(.DATA_W(32)) imem_if ();

    pc_fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset(Reset), .Inst_Reg_Write(Inst_Reg_Write),
        .PC_Write_Or(PC_Write_Or), .PC_Write_And(PC_Write_And),
        .PC_Selector_Source(PC_Selector_Source), .BorN(BorN),
        .Zero(Zero), .Less(Less), .ALU_Result(ALU_Result), .ALU_Out(ALU_Out),
        .imem(imem_if), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm),
        .Stall(Stall), .Fetch_Error(Fetch_Error), .Instr_Count(Instr_Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        Reset = 1'b1; Inst_Reg_Write = 1'b0; PC_Write_Or = 1'b0; PC_Write_And = 1'b0;
        PC_Selector_Source = 2'b00; BorN = 2'b00; Zero = 1'b0; Less = 1'b0;
        ALU_Result = 32'h0; ALU_Out = 32'h0;
        imem_if.Imem_Data = 32'h0; imem_if.Imem_Ready = 1'b0;
        step(); step();
        Reset = 1'b0;
        settle();

        // reset state
        expect_val("rst_pc", 32'h0);     chk(imem_if.Imem_Addr);
        expect_val("rst_opcode", 32'h0); chk({26'h0, Opcode});
        expect_val("rst_stall", 32'h0);  chk({31'h0, Stall});
        expect_val("rst_req", 32'h0);    chk({31'h0, imem_if.Imem_Req});
        expect_val("rst_err", 32'h0);    chk({31'h0, Fetch_Error});
        expect_val("rst_count", 32'h0);  chk(Instr_Count);

        // zero-wait fetch
        Inst_Reg_Write = 1'b1; PC_Write_Or = 1'b1; PC_Selector_Source = 2'b00;
        ALU_Result = 32'h4; imem_if.Imem_Ready = 1'b1; imem_if.Imem_Data = 32'h2C22_0005;
        settle();
        expect_val("zw_stall", 32'h0); chk({31'h0, Stall});
        expect_val("zw_req", 32'h1);   chk({31'h0, imem_if.Imem_Req});
        step();
        Inst_Reg_Write = 1'b0; PC_Write_Or = 1'b0; imem_if.Imem_Ready = 1'b0;
        settle();
        expect_val("zw_opcode", 32'h0B);   chk({26'h0, Opcode});
        expect_val("zw_rs", 32'h1);        chk({27'h0, Rs});
        expect_val("zw_rt", 32'h2);        chk({27'h0, Rt});
        expect_val("zw_imm", 32'h5);       chk({16'h0, Imm});
        expect_val("zw_pc", 32'h4);        chk(imem_if.Imem_Addr);
        expect_val("zw_count", 32'h1);     chk(Instr_Count);

        // three wait states
        Inst_Reg_Write = 1'b1; PC_Write_Or = 1'b1; ALU_Result = 32'h8;
        imem_if.Imem_Data = 32'h0000_1234;
        settle();
        for (int i = 0; i < 3; i++) begin
            expect_val("w3_stall", 32'h1); chk({31'h0, Stall});
            expect_val("w3_req", 32'h1);   chk({31'h0, imem_if.Imem_Req});
            expect_val("w3_pc", 32'h4);    chk(imem_if.Imem_Addr);
            step();
        end
        imem_if.Imem_Ready = 1'b1;
        settle();
        expect_val("w3_stall_done", 32'h0); chk({31'h0, Stall});
        step();
        Inst_Reg_Write = 1'b0; PC_Write_Or = 1'b0; imem_if.Imem_Ready = 1'b0;
        settle();
        expect_val("w3_pc_after", 32'h8);  chk(imem_if.Imem_Addr);
        expect_val("w3_imm", 32'h1234);    chk({16'h0, Imm});
        expect_val("w3_count", 32'h2);     chk(Instr_Count);

        // branches through ALU_Out
        PC_Write_And = 1'b1; PC_Selector_Source = 2'b01;
        ALU_Out = 32'h40; BorN = 2'b00; Zero = 1'b1; Less = 1'b0;
        step();
        expect_val("beq_taken", 32'h40); chk(imem_if.Imem_Addr);
        ALU_Out = 32'h80; Zero = 1'b0;
        step();
        expect_val("beq_not", 32'h40); chk(imem_if.Imem_Addr);
        BorN = 2'b11; Zero = 1'b1; Less = 1'b0;
        step();
        expect_val("ble_taken", 32'h80); chk(imem_if.Imem_Addr);
        ALU_Out = 32'hC0; BorN = 2'b10; Less = 1'b0; Zero = 1'b1;
        step();
        expect_val("blt_not", 32'h80); chk(imem_if.Imem_Addr);
        BorN = 2'b01; Zero = 1'b0;
        step();
        expect_val("bne_taken", 32'hC0); chk(imem_if.Imem_Addr);
        PC_Write_And = 1'b0;

        // jump: load IR with index 0x100, then PC = 0xA000_0010
        Inst_Reg_Write = 1'b1; imem_if.Imem_Ready = 1'b1; imem_if.Imem_Data = 32'h0800_0100;
        step();
        Inst_Reg_Write = 1'b0; imem_if.Imem_Ready = 1'b0;
        PC_Write_Or = 1'b1; PC_Selector_Source = 2'b00; ALU_Result = 32'hA000_0010;
        step();
        expect_val("jmp_setup_pc", 32'hA000_0010); chk(imem_if.Imem_Addr);
        PC_Selector_Source = 2'b10;
        step();
        expect_val("jmp_pc", 32'hA000_0400); chk(imem_if.Imem_Addr);
        PC_Selector_Source = 2'b11;
        step();
        expect_val("hold_pc", 32'hA000_0400); chk(imem_if.Imem_Addr);
        expect_val("jmp_count", 32'h3);       chk(Instr_Count);

        // timeout with a pending PC write that must be ignored
        PC_Selector_Source = 2'b00; ALU_Result = 32'h1111_0000;
        Inst_Reg_Write = 1'b1; imem_if.Imem_Data = 32'hFFFF_FFFF;
        settle();
        for (int i = 0; i < TO + 1; i++) begin
            expect_val("to_stall", 32'h1); chk({31'h0, Stall});
            expect_val("to_err_low", 32'h0); chk({31'h0, Fetch_Error});
            step();
        end
        Inst_Reg_Write = 1'b0; PC_Write_Or = 1'b0;
        settle();
        expect_val("to_err", 32'h1);          chk({31'h0, Fetch_Error});
        expect_val("to_opcode", 32'h0);       chk({26'h0, Opcode});
        expect_val("to_imm", 32'h0);          chk({16'h0, Imm});
        expect_val("to_pc", 32'hA000_0400);   chk(imem_if.Imem_Addr);
        expect_val("to_stall_after", 32'h0); chk({31'h0, Stall});
        expect_val("to_count", 32'h3);        chk(Instr_Count);

        // good fetch afterwards keeps the sticky error
        Inst_Reg_Write = 1'b1; imem_if.Imem_Ready = 1'b1; imem_if.Imem_Data = 32'h0C00_0007;
        step();
        Inst_Reg_Write = 1'b0; imem_if.Imem_Ready = 1'b0;
        settle();
        expect_val("sticky_err", 32'h1); chk({31'h0, Fetch_Error});
        expect_val("post_imm", 32'h7);   chk({16'h0, Imm});
        expect_val("post_count", 32'h4); chk(Instr_Count);

        // reset in the middle of a wait (counter at 5)
        Inst_Reg_Write = 1'b1;
        for (int i = 0; i < 6; i++) step();
        expect_val("mid_stall", 32'h1); chk({31'h0, Stall});
        Reset = 1'b1;
        step();
        Reset = 1'b0; Inst_Reg_Write = 1'b0;
        settle();
        expect_val("mr_pc", 32'h0);     chk(imem_if.Imem_Addr);
        expect_val("mr_stall", 32'h0);  chk({31'h0, Stall});
        expect_val("mr_req", 32'h0);    chk({31'h0, imem_if.Imem_Req});
        expect_val("mr_imm", 32'h0);    chk({16'h0, Imm});
        expect_val("mr_opcode", 32'h0); chk({26'h0, Opcode});
        expect_val("mr_count", 32'h0);  chk(Instr_Count);
        expect_val("mr_err", 32'h0);    chk({31'h0, Fetch_Error});

        // wait counter restarts from zero: a full timeout takes TO wait cycles again
        Inst_Reg_Write = 1'b1;
        for (int i = 0; i < TO; i++) step();
        expect_val("mr_err_before", 32'h0); chk({31'h0, Fetch_Error});
        step();
        Inst_Reg_Write = 1'b0;
        settle();
        expect_val("mr_err_after", 32'h1); chk({31'h0, Fetch_Error});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream and downstream neighbour of the multi-cycle control FSM.
- Holds the program counter (PC) and the instruction register (IR), and drives Opcode to the control unit.
- Resolves PC writes from the control unit's PC_Write_Or, PC_Write_And, BorN and PC_Selector_Source, using the ALU flags.
- Adds a ready handshake to instruction memory, stalling the fetch until the instruction arrives. A timeout sets a sticky error flag.

Parameters:
DATA_W, 32, width of PC, IR, ALU operands and instruction memory data
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 15, maximum wait cycles for Imem_Ready before Fetch_Error sets (range 1..255)

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high reset
Inst_Reg_Write  in  1  control: latch the fetched instruction and perform the fetch PC write
PC_Write_Or  in  1  control: unconditional PC write
PC_Write_And  in  1  control: conditional (branch) PC write
PC_Selector_Source  in  2  PC source: 00 ALU_Result, 01 ALU_Out, 10 jump target, 11 hold
BorN  in  2  branch type: 00 BEQ, 01 BNE, 10 BLT, 11 BLE
Zero  in  1  ALU result == 0
Less  in  1  ALU signed less-than flag
ALU_Result  in  DATA_W  combinational ALU output
ALU_Out  in  DATA_W  registered ALU output (branch target)
Imem_Data  in  DATA_W  instruction memory read data
Imem_Ready  in  1  Imem_Data valid this cycle
Imem_Addr  out  DATA_W  current PC
Imem_Req  out  1  fetch request
Opcode  out  6  IR[31:26]
Rs  out  5  IR[25:21]
Rt  out  5  IR[20:16]
Rd  out  5  IR[15:11]
Imm  out  16  IR[15:0]
Stall  out  1  fetch waiting; the control FSM must hold state
Fetch_Error  out  1  sticky: fetch timeout occurred
Instr_Count  out  32  count of instructions latched into IR

Behaviour:
- All state updates on posedge CLK.
- Reset (synchronous, active-high) has priority over everything, including a fetch in progress or a pending PC write. Reset values:
  - PC = RESET_PC, IR = 0, so Opcode = 0 (NOOP)
  - FSM = IDLE, wait counter = 0
  - Stall = 0, Imem_Req = 0, Fetch_Error = 0, Instr_Count = 0
- Fetch FSM:
  - IDLE: Imem_Req = Inst_Reg_Write.
    - Inst_Reg_Write = 1 and Imem_Ready = 1: this cycle latch IR <= Imem_Data, apply the PC write, increment Instr_Count; stay in IDLE. Zero wait states.
    - Inst_Reg_Write = 1 and Imem_Ready = 0: go to WAIT. Stall = 1 combinationally in this same cycle. No IR or PC update.
  - WAIT: Imem_Req = 1, Stall = 1, wait counter increments each cycle.
    - Imem_Ready = 1: latch IR, apply the PC write, increment Instr_Count, clear the counter, go to IDLE. Stall = 0 in that cycle.
    - Counter reaches FETCH_TIMEOUT: set Fetch_Error, latch IR <= 0 (NOOP), do not write PC, go to IDLE.
  - While in WAIT, all PC-write inputs are ignored.
- PC write, evaluated only when not stalled:
  - Branch condition taken:
    - BorN 00: Zero
    - BorN 01: !Zero
    - BorN 10: Less
    - BorN 11: Less | Zero
  - pc_we = PC_Write_Or | (PC_Write_And & taken).
- PC next-value mux:
  - 00: ALU_Result
  - 01: ALU_Out
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: PC unchanged, even when pc_we = 1
- Jump target uses the IR value before any same-cycle IR load. The control unit never jumps while fetching.
- Imem_Addr = PC at all times. The PC write applied at a fetch uses the PC value before the update.
- Instr_Count wraps from 2^32-1 to 0. A timeout NOOP does not increment it.
- Fetch_Error clears only on Reset.
- PC low two bits are written as given; there is no alignment check.

Test Plan:
- Reset mid-WAIT (counter at 5): assert Reset for 1 cycle -> PC = RESET_PC, Stall = 0, IR = 0, Instr_Count = 0, Fetch_Error = 0.
- Zero-wait fetch: PC = 0, Inst_Reg_Write = 1, PC_Write_Or = 1, src = 00, ALU_Result = 4, Imem_Ready = 1, Imem_Data = 0x2C22_0005 -> next cycle IR = 0x2C22_0005, Opcode = 0x0B, PC = 4, Instr_Count = 1.
- 3-cycle wait: Imem_Ready low for 3 cycles -> Stall = 1 for exactly 3 cycles, PC unchanged throughout, IR latched on the 4th cycle, PC = 4 after.
- Branches, with ALU_Out = 0x40 and PC_Write_And = 1, src = 01:
  - BEQ with Zero = 1 -> PC = 0x40
  - BEQ with Zero = 0 -> PC unchanged
  - BLE with Less = 0, Zero = 1 -> PC = 0x40
  - BLT with Less = 0 -> PC unchanged
- Jump: PC = 0xA000_0010, IR[25:0] = 0x000_0100, PC_Write_Or = 1, src = 10 -> PC = 0xA000_0400. Same inputs with src = 11 -> PC unchanged.
- Timeout: FETCH_TIMEOUT = 15, Imem_Ready held 0 -> Fetch_Error = 1 after 15 WAIT cycles, IR = 0, PC unchanged, Stall = 0. Fetch_Error persists across later good fetches.
